// File: rtl/if_fetch_unit.sv
// IF-stage fetch controller: owns the PC, fetches over a req/ack memory handshake,
// and holds the IF/ID register with a one-entry skid buffer behind it.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] drain_addr;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        fetch_ack;
  logic        ifid_accept;

  // In DRAIN the memory still owes us the old request, so the address it saw
  // must stay on the bus even though pc already points at the redirect target.
  assign imem_req    = ((state == FETCH) && !skid_valid) || (state == DRAIN);
  assign imem_addr   = (state == DRAIN) ? drain_addr : pc;
  assign ifid_flush  = redirect_valid;
  assign idex_flush  = redirect_valid;
  assign fetch_ack   = (state == FETCH) && !skid_valid && imem_ack;
  assign ifid_accept = !stall || !ifid_valid;

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what lets pc, IF/ID and the skid buffer change in the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      drain_addr   <= RESET_PC;
      ifid_valid   <= 1'b0;
      ifid_pc      <= 32'h0;
      ifid_inst    <= NOP_INST;
      skid_valid   <= 1'b0;
      skid_pc      <= 32'h0;
      skid_inst    <= NOP_INST;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect beats stall: wrong-path IF/ID and skid contents are dropped,
      // and any same-cycle response is ignored.
      pc         <= {redirect_pc[31:2], 2'b00};
      ifid_valid <= 1'b0;
      ifid_inst  <= NOP_INST;
      skid_valid <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (imem_req && !imem_ack) begin
            state      <= DRAIN;
            drain_addr <= pc;
          end
        end
        DRAIN: state <= DRAIN;
        // NOTE: the unused encoding recovers to IDLE instead of locking up.
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (fetch_ack) pc <= pc + 32'd4;
        DRAIN: if (imem_ack) state <= FETCH;
        default: state <= IDLE;
      endcase

      if (ifid_accept) begin
        if (skid_valid) begin
          ifid_valid <= 1'b1;
          ifid_pc    <= skid_pc;
          ifid_inst  <= skid_inst;
          skid_valid <= 1'b0;
        end else if (fetch_ack) begin
          ifid_valid <= 1'b1;
          ifid_pc    <= pc;
          ifid_inst  <= imem_rdata;
        end else begin
          ifid_valid <= 1'b0;
          ifid_inst  <= NOP_INST;
        end
      end else if (fetch_ack) begin
        // IF/ID is stalled with a live instruction; park the response.
        skid_valid <= 1'b1;
        skid_pc    <= pc;
        skid_inst  <= imem_rdata;
      end
    end
  end

endmodule
